// File: rtl/rmt_pkg.sv
// Shared definitions for the RMT egress dispatch path.
// Default geometry, dispatcher state encoding and bitmap helpers.
package rmt_pkg;

   localparam int PHV_LEN_DEF = 2304;
   localparam int DST_OFF_DEF = 141;
   localparam int NUM_OUT_DEF = 4;

   typedef enum logic {
      IDLE,
      HOLD
   } state_e;

   // One-hot destination code for a single port (up to 16 ports).
   function automatic logic [15:0] dst_onehot(input int unsigned port);
      return 16'(1) << port;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones once reached.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/phv_port_dispatch.sv
// Egress dispatcher: fans the final PHV out to per-port queues.
// Multicast ports are served independently as each one becomes ready.
module phv_port_dispatch
   import rmt_pkg::*;
#(
   parameter int PHV_LEN        = PHV_LEN_DEF,
   parameter int NUM_OUT        = NUM_OUT_DEF,
   parameter int DST_OFF        = DST_OFF_DEF,
   parameter int ONEHOT_REWRITE = 0,
   parameter int CNT_W          = 32
) (
   input  logic                       axis_clk,
   input  logic                       areset,
   input  logic [PHV_LEN-1:0]         phv_in,
   input  logic                       phv_in_valid,
   output logic                       phv_in_ready,
   input  logic [NUM_OUT-1:0]         port_en,
   output logic [NUM_OUT*PHV_LEN-1:0] phv_out,
   output logic [NUM_OUT-1:0]         phv_out_valid,
   input  logic [NUM_OUT-1:0]         phv_out_ready,
   output logic [CNT_W-1:0]           drop_cnt,
   output logic [CNT_W-1:0]           mcast_cnt,
   output logic                       busy
);

   state_e               state_q, state_d;
   logic [NUM_OUT-1:0]   pend_q, pend_d;
   logic [PHV_LEN-1:0]   hold_q, hold_d;

   logic [NUM_OUT-1:0]   eff;
   logic [NUM_OUT-1:0]   acc;
   logic [NUM_OUT-1:0]   rem;
   logic                 done;
   logic                 cap;
   logic                 cap_keep;
   logic                 inc_drop;
   logic                 inc_mcast;

   assign eff  = phv_in[DST_OFF +: NUM_OUT] & port_en;
   assign acc  = pend_q & phv_out_ready;
   assign rem  = pend_q & ~acc;
   assign done = (rem == '0);

   assign phv_in_ready = (state_q == IDLE) || done;
   assign cap          = phv_in_valid && phv_in_ready;
   assign cap_keep     = cap && (eff != '0);
   assign inc_drop     = cap && (eff == '0);
   // Two or more bits set: clearing the lowest set bit leaves something.
   assign inc_mcast    = cap && ((eff & (eff - NUM_OUT'(1))) != '0);

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (cap_keep) begin
               state_d = HOLD;
               pend_d  = eff;
               hold_d  = phv_in;
            end
         end
         HOLD: begin
            pend_d = rem;
            if (done) begin
               if (cap_keep) begin
                  pend_d = eff;
                  hold_d = phv_in;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         state_q <= IDLE;
         pend_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         hold_q  <= hold_d;
      end
   end

   assign busy          = (state_q == HOLD);
   assign phv_out_valid = busy ? pend_q : '0;

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
      logic [PHV_LEN-1:0] slice;
      always_comb begin
         slice = hold_q;
         if (ONEHOT_REWRITE != 0) begin
            slice[DST_OFF +: NUM_OUT] = NUM_OUT'(dst_onehot(i));
         end
      end
      assign phv_out[i*PHV_LEN +: PHV_LEN] = slice;
   end

   sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk_i (axis_clk),
      .rst_i (areset),
      .inc_i (inc_drop),
      .cnt_o (drop_cnt)
   );

   sat_counter #(.W(CNT_W)) u_mcast_cnt (
      .clk_i (axis_clk),
      .rst_i (areset),
      .inc_i (inc_mcast),
      .cnt_o (mcast_cnt)
   );

endmodule

// File: tb/tb_phv_port_dispatch.sv
// Scoreboard bench for phv_port_dispatch: plain and rewrite/4-bit variants.
// Both instances share stimulus; a negedge monitor checks against the model.
module tb_phv_port_dispatch;

   localparam int PL = 2304;
   localparam int NO = 4;
   localparam int DO = 141;

   logic              clk = 1'b0;
   logic              areset;
   logic [PL-1:0]     phv_in;
   logic              phv_in_valid;
   logic [NO-1:0]     port_en;
   logic [NO-1:0]     phv_out_ready;

   logic [NO*PL-1:0]  out0, out1;
   logic [NO-1:0]     v0, v1;
   logic              r0, r1, b0, b1;
   logic [31:0]       d0, m0;
   logic [3:0]        d1, m1;

   phv_port_dispatch #(
      .PHV_LEN(PL), .NUM_OUT(NO), .DST_OFF(DO),
      .ONEHOT_REWRITE(0), .CNT_W(32)
   ) dut0 (
      .axis_clk(clk), .areset(areset),
      .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(r0),
      .port_en(port_en),
      .phv_out(out0), .phv_out_valid(v0), .phv_out_ready(phv_out_ready),
      .drop_cnt(d0), .mcast_cnt(m0), .busy(b0)
   );

   phv_port_dispatch #(
      .PHV_LEN(PL), .NUM_OUT(NO), .DST_OFF(DO),
      .ONEHOT_REWRITE(1), .CNT_W(4)
   ) dut1 (
      .axis_clk(clk), .areset(areset),
      .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(r1),
      .port_en(port_en),
      .phv_out(out1), .phv_out_valid(v1), .phv_out_ready(phv_out_ready),
      .drop_cnt(d1), .mcast_cnt(m1), .busy(b1)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [PL-1:0] q [NO][$];
   logic [NO-1:0] pend_m;
   longint        n_drop, n_mc;
   bit            mon_en = 1'b0;
   bit            ready_rand = 1'b0;

   function automatic logic [PL-1:0] rw(input logic [PL-1:0] d, input int i);
      logic [PL-1:0] r;
      r = d;
      r[DO +: NO] = NO'(1 << i);
      return r;
   endfunction

   function automatic longint satv(input longint n, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkd(input string nm, input int port,
                       input logic [PL-1:0] act, input logic [PL-1:0] exp);
      int b;
      checks++;
      if (act !== exp) begin
         errors++;
         b = 0;
         for (int k = PL - 1; k >= 0; k--) if (act[k] !== exp[k]) b = k;
         b = (b / 32) * 32;
         $display("FAIL %s port %0d: bits[%0d+:32] got %h expected %h t=%0t",
                  nm, port, b, act[b +: 32], exp[b +: 32], $time);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         logic          exp_rdy;
         logic [NO-1:0] eff;
         exp_rdy = ((pend_m & ~phv_out_ready) == '0);
         chk("valid0", 64'(v0), 64'(pend_m));
         chk("valid1", 64'(v1), 64'(pend_m));
         chk("in_ready0", 64'(r0), 64'(exp_rdy));
         chk("in_ready1", 64'(r1), 64'(exp_rdy));
         chk("busy0", 64'(b0), 64'(pend_m != '0));
         chk("busy1", 64'(b1), 64'(pend_m != '0));
         chk("drop0", 64'(d0), 64'(satv(n_drop, 32)));
         chk("mcast0", 64'(m0), 64'(satv(n_mc, 32)));
         chk("drop1", 64'(d1), 64'(satv(n_drop, 4)));
         chk("mcast1", 64'(m1), 64'(satv(n_mc, 4)));
         for (int i = 0; i < NO; i++) begin
            if (pend_m[i]) begin
               if (q[i].size() == 0) begin
                  chk("sb_empty", 64'(i), 64'hFFFF);
               end else begin
                  chkd("data0", i, out0[i*PL +: PL], q[i][0]);
                  chkd("data1", i, out1[i*PL +: PL], rw(q[i][0], i));
               end
            end
         end
         if (areset) begin
            for (int i = 0; i < NO; i++) q[i].delete();
            pend_m = '0;
            n_drop = 0;
            n_mc   = 0;
         end else begin
            for (int i = 0; i < NO; i++)
               if (pend_m[i] && phv_out_ready[i] && q[i].size() > 0)
                  void'(q[i].pop_front());
            pend_m = pend_m & ~phv_out_ready;
            if (phv_in_valid && exp_rdy) begin
               eff = phv_in[DO +: NO] & port_en;
               if (eff == '0) begin
                  n_drop++;
               end else begin
                  for (int i = 0; i < NO; i++)
                     if (eff[i]) q[i].push_back(phv_in);
                  pend_m = eff;
                  if ($countones(eff) >= 2) n_mc++;
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      if (ready_rand) begin
         #1;
         phv_out_ready = NO'($urandom);
      end
   end

   task automatic send(input logic [NO-1:0] bm, output int waited);
      logic [PL-1:0] p;
      for (int w = 0; w < PL / 32; w++) p[w*32 +: 32] = $urandom;
      p[DO +: NO] = bm;
      phv_in = p;
      phv_in_valid = 1'b1;
      waited = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (r0) begin
            @(posedge clk);
            #1;
            phv_in_valid = 1'b0;
            return;
         end
         waited++;
         @(posedge clk);
         #1;
      end
      chk("send_timeout", 64'(waited), 64'd0);
      phv_in_valid = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int     w;
      longint base;
      areset        = 1'b1;
      phv_in        = '0;
      phv_in_valid  = 1'b0;
      port_en       = '1;
      phv_out_ready = '1;
      pend_m        = '0;
      n_drop        = 0;
      n_mc          = 0;
      cyc(3);
      areset = 1'b0;
      @(negedge clk);
      chk("rst_valid", 64'(v0), 64'd0);
      chk("rst_out", 64'(out0 != '0), 64'd0);
      chk("rst_ready", 64'(r0), 64'd1);
      chk("rst_busy", 64'(b0), 64'd0);
      chk("rst_drop", 64'(d0), 64'd0);
      chk("rst_mcast", 64'(m0), 64'd0);
      mon_en = 1'b1;
      @(posedge clk); #1;

      // unicast fast path
      send(4'b0001, w); chk("t1_wait0", 64'(w), 64'd0);
      send(4'b0100, w); chk("t1_wait1", 64'(w), 64'd0);
      send(4'b1000, w); chk("t1_wait2", 64'(w), 64'd0);
      cyc(2);

      // multicast with staggered ready
      base = n_mc;
      phv_out_ready = 4'b0000;
      send(4'b1011, w);
      phv_out_ready = 4'b0001; cyc(1);
      phv_out_ready = 4'b1000; cyc(1);
      phv_out_ready = 4'b0010; cyc(1);
      phv_out_ready = 4'b0000; cyc(1);
      @(negedge clk);
      chk("t2_mcast", 64'(m0), 64'(base + 1));
      chk("t2_idle", 64'(v0), 64'd0);
      @(posedge clk); #1;

      // drops
      base = n_drop;
      phv_out_ready = '1;
      send(4'b0000, w); chk("t3_wait0", 64'(w), 64'd0);
      port_en = 4'b1011;
      send(4'b0100, w); chk("t3_wait1", 64'(w), 64'd0);
      port_en = '1;
      @(negedge clk);
      chk("t3_drop", 64'(d0), 64'(base + 2));
      @(posedge clk); #1;

      // broadcast, rewrite checked on dut1 slices
      send(4'b1111, w);
      cyc(2);

      // backpressure hold
      phv_out_ready = 4'b0000;
      send(4'b0010, w);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t5_valid", 64'(v0[1]), 64'd1);
         chk("t5_inrdy", 64'(r0), 64'd0);
         @(posedge clk); #1;
      end
      phv_out_ready = 4'b0010; cyc(1);
      phv_out_ready = 4'b0000;
      @(negedge clk);
      chk("t5_done", 64'(v0), 64'd0);
      @(posedge clk); #1;

      // randomized traffic
      ready_rand = 1'b1;
      for (int n = 0; n < 300; n++) begin
         port_en = NO'($urandom);
         if ($urandom_range(0, 3) == 0) port_en = '1;
         send(NO'($urandom), w);
      end
      ready_rand = 1'b0;
      @(posedge clk); #2;
      phv_out_ready = '1;
      port_en = '1;
      cyc(3);

      // reset mid-hold, then saturation of the 4-bit counters
      phv_out_ready = 4'b0000;
      send(4'b0110, w);
      cyc(1);
      areset = 1'b1;
      cyc(1);
      areset = 1'b0;
      @(negedge clk);
      chk("t6_valid0", 64'(v0), 64'd0);
      chk("t6_valid1", 64'(v1), 64'd0);
      chk("t6_drop", 64'(d0), 64'd0);
      chk("t6_mcast", 64'(m1), 64'd0);
      @(posedge clk); #1;
      phv_out_ready = '1;
      for (int n = 0; n < 20; n++) send(4'b0000, w);
      @(negedge clk);
      chk("t6_sat1", 64'(d1), 64'd15);
      chk("t6_cnt0", 64'(d0), 64'd20);
      for (int i = 0; i < NO; i++) chk("sb_left", 64'(q[i].size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
